// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants, types and helpers for the GRF write-back arbiter.
// Requester indices double as priority slots for the round-robin pointer.
package grf_wb_arbiter_pkg;

    localparam int NUM_REQ    = 3;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_ALU = 2'd0;
    localparam req_idx_t REQ_MEM = 2'd1;
    localparam req_idx_t REQ_MD  = 2'd2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [DATA_W-1:0]     pc;
    } wb_req_t;

    // Modulo-3 addition on requester indices (operands are always 0..2).
    function automatic req_idx_t add_mod3(input req_idx_t a, input req_idx_t b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sum = (sum >= 3'd3) ? (sum - 3'd3) : sum;
        return sum[1:0];
    endfunction

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Requester-side bundle of the write-back arbiter: three valid/ready write
// channels plus the register-claim port that feeds the busy scoreboard.
interface grf_wb_arbiter_if;
    import grf_wb_arbiter_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0]     req_data;
    logic [NUM_REQ*DATA_W-1:0]     req_pc;
    logic                          claim_valid;
    logic [REG_ADDR_W-1:0]         claim_addr;

    modport master (
        output req_valid, req_addr, req_data, req_pc, claim_valid, claim_addr,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_pc, claim_valid, claim_addr,
        output req_ready
    );

endinterface

// File: rtl/grf_wb_arbiter_rr_pick3.sv
// Three-way round-robin picker: the first valid requester found when
// searching ptr, ptr+1, ptr+2 (mod 3) wins.
module rr_pick3
    import grf_wb_arbiter_pkg::*;
(
    input  logic [2:0] valid,
    input  req_idx_t   ptr,
    output logic [2:0] grant,
    output req_idx_t   index
);

    logic [2:0] rot_s;
    req_idx_t   offset_s;
    logic       any_s;

    // Rotate valid so that bit 0 is the highest-priority requester.
    always_comb begin
        rot_s = valid;
        case (ptr)
            2'd0:    rot_s = valid;
            2'd1:    rot_s = {valid[0], valid[2], valid[1]};
            2'd2:    rot_s = {valid[1], valid[0], valid[2]};
            default: rot_s = valid;
        endcase
    end

    // Fixed-priority search over the rotated request vector.
    always_comb begin
        offset_s = 2'd0;
        any_s    = 1'b0;
        if (rot_s[0]) begin
            offset_s = 2'd0;
            any_s    = 1'b1;
        end else if (rot_s[1]) begin
            offset_s = 2'd1;
            any_s    = 1'b1;
        end else if (rot_s[2]) begin
            offset_s = 2'd2;
            any_s    = 1'b1;
        end else begin
            offset_s = 2'd0;
            any_s    = 1'b0;
        end
    end

    // Map the winning slot back to the absolute requester index.
    always_comb begin
        index = add_mod3(ptr, offset_s);
        if (any_s) begin
            grant = 3'b001 << index;
        end else begin
            grant = 3'b000;
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-back arbiter: round-robin grant among ALU/MEM/MD, one-cycle
// registered register-file write port, and a pending-write busy scoreboard.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    grf_wb_arbiter_if.slave       bus,
    output logic [31:0]           busy,
    output logic                  grf_we,
    output logic [REG_ADDR_W-1:0] grf_a3,
    output logic [DATA_W-1:0]     grf_wd,
    output logic [DATA_W-1:0]     grf_pc
);

    req_idx_t              rr_ptr_r;
    logic [2:0]            grant_s;
    req_idx_t              index_s;
    logic [2:0]            ready_s;
    logic                  granted_s;
    wb_req_t               sel_s;
    logic [31:0]           busy_r;
    logic [31:0]           busy_nxt_s;
    logic [31:0]           clr_mask_s;
    logic [31:0]           set_mask_s;
    logic                  grf_we_r;
    logic [REG_ADDR_W-1:0] grf_a3_r;
    logic [DATA_W-1:0]     grf_wd_r;
    logic [DATA_W-1:0]     grf_pc_r;

    rr_pick3 u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .index (index_s)
    );

    // Grants are suppressed while reset is held so nothing transfers then.
    always_comb begin
        if (reset) begin
            ready_s = 3'b000;
        end else begin
            ready_s = grant_s;
        end
    end

    assign bus.req_ready = ready_s;
    assign granted_s     = |ready_s;

    // Select the granted requester's fields.
    always_comb begin
        sel_s = '{addr: bus.req_addr[4:0], data: bus.req_data[31:0], pc: bus.req_pc[31:0]};
        case (index_s)
            REQ_ALU: sel_s = '{addr: bus.req_addr[4:0],   data: bus.req_data[31:0],  pc: bus.req_pc[31:0]};
            REQ_MEM: sel_s = '{addr: bus.req_addr[9:5],   data: bus.req_data[63:32], pc: bus.req_pc[63:32]};
            REQ_MD:  sel_s = '{addr: bus.req_addr[14:10], data: bus.req_data[95:64], pc: bus.req_pc[95:64]};
            default: sel_s = '{addr: bus.req_addr[4:0],   data: bus.req_data[31:0],  pc: bus.req_pc[31:0]};
        endcase
    end

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= 2'd0;
        end else if (granted_s) begin
            rr_ptr_r <= add_mod3(index_s, 2'd1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Scoreboard update: set is applied after clear so a same-cycle claim wins.
    always_comb begin
        clr_mask_s = (granted_s && (sel_s.addr != 5'd0)) ? (32'd1 << sel_s.addr) : 32'd0;
        set_mask_s = (bus.claim_valid && (bus.claim_addr != 5'd0)) ? (32'd1 << bus.claim_addr) : 32'd0;
        busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Registered GRF write port; writes to $0 are accepted but never enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we_r <= 1'b0;
            grf_a3_r <= 5'd0;
            grf_wd_r <= 32'd0;
            grf_pc_r <= 32'd0;
        end else if (granted_s) begin
            grf_we_r <= (sel_s.addr != 5'd0);
            grf_a3_r <= sel_s.addr;
            grf_wd_r <= sel_s.data;
            grf_pc_r <= sel_s.pc;
        end else begin
            grf_we_r <= 1'b0;
            grf_a3_r <= grf_a3_r;
            grf_wd_r <= grf_wd_r;
            grf_pc_r <= grf_pc_r;
        end
    end

    assign busy   = busy_r;
    assign grf_we = grf_we_r;
    assign grf_a3 = grf_a3_r;
    assign grf_wd = grf_wd_r;
    assign grf_pc = grf_pc_r;

endmodule

// File: doc/grf_wb_arbiter.md
GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 SHALL: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: req_valid  input  3  per-requester write request; bit0 ALU, bit1 MEM, bit2 MD.
REQ-004 SHALL: req_ready  output  3  per-requester grant; a transfer completes on a cycle where valid&ready are both 1.
REQ-005 SHALL: req_addr  input  15  destination register per requester, 5 bits each, requester i in bits [5i+4:5i].
REQ-006 SHALL: req_data  input  96  write data per requester, 32 bits each, requester i in bits [32i+31:32i].
REQ-007 SHALL: req_pc  input  96  instruction PC per requester, 32 bits each, packed as req_data.
REQ-008 SHALL: claim_valid  input  1  marks req_addr-independent destination claim_addr as pending.
REQ-009 SHALL: claim_addr  input  5  register being claimed.
REQ-010 SHALL: busy  output  32  scoreboard; bit n = write to $n pending.
REQ-011 SHALL: grf_we, grf_a3(5), grf_wd(32), grf_pc(32)  outputs  registered GRF write port.

Function
REQ-012 SHALL: at most one req_ready bit high per cycle; req_ready[i] only when req_valid[i].
REQ-013 SHALL: arbitrate round-robin; pointer rr_ptr (0..2) is highest-priority index; search order rr_ptr, rr_ptr+1, rr_ptr+2 mod 3.
REQ-014 SHALL: after a grant to requester g, rr_ptr <= (g+1) mod 3; with no grant rr_ptr holds.
REQ-015 SHALL: req_ready combinational from req_valid and rr_ptr; no dependence on req_data.
REQ-016 SHALL: latency exactly 1 cycle: grant in cycle N -> grf_we=1, grf_a3/wd/pc = granted fields in cycle N+1.
REQ-017 SHALL: grant with addr 0 is accepted (ready=1) but produces grf_we=0 in N+1.
REQ-018 SHALL: with no grant in cycle N, grf_we=0 in N+1; grf_a3/wd/pc hold previous values.
REQ-019 SHALL: any request held valid is granted within 3 cycles (no starvation).
REQ-020 SHALL: claim_valid with claim_addr!=0 sets busy[claim_addr] at next edge; claim of 0 ignored; busy[0] always 0.
REQ-021 SHALL: grant to address a!=0 clears busy[a] at next edge.
REQ-022 SHALL: same-cycle claim and grant on same register -> busy bit ends 1 (claim wins).
REQ-023 SHALL: grant to a register whose busy bit is already 0 is still written; busy unchanged.
REQ-024 SHALL: requester may change addr/data while valid&!ready; only values sampled at grant are used.

Reset
REQ-025 SHALL: reset asserted -> next edge: busy=0, rr_ptr=0, grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0.
REQ-026 SHALL: while reset is high req_ready=0; requests and claims in that cycle are discarded.
REQ-027 SHALL: reset mid-stream drops any grant of that cycle; first cycle after reset arbitrates from rr_ptr=0.

Structure
REQ-028 SHALL: shared package holds NUM_REQ=3, REG_ADDR_W=5, DATA_W=32, requester index constants REQ_ALU/REQ_MEM/REQ_MD.
REQ-029 SHALL: round-robin selection in one sub-module rr_pick3 (inputs valid[2:0], ptr; outputs onehot grant, index); scoreboard and output register in top.

Verification
REQ-030 SHALL: V1 reset, then ALU valid addr=5 data=0x1234 pc=0x3000 -> ready[0] same cycle; next cycle grf_we=1, a3=5, wd=0x1234, pc=0x3000.
REQ-031 SHALL: V2 all three valid continuously from reset -> grants 0,1,2,0,... one per cycle; rr_ptr sequence 1,2,0.
REQ-032 SHALL: V3 MEM valid addr=0 data=0xFFFFFFFF -> ready[1]=1, next cycle grf_we=0.
REQ-033 SHALL: V4 claim 8 cycle 0; MD grant addr=8 cycle 3 -> busy[8]=1 cycles 1..3, 0 from cycle 4; claim 8 plus grant 8 same cycle -> busy[8]=1 after.
REQ-034 SHALL: V5 claim addr=0 -> busy stays 0x00000000.
REQ-035 SHALL: V6 three requests pending, busy=0x00000110, reset for one cycle -> all outputs 0, busy=0, next grant goes to ALU.
